// File: rtl/toggle_event_decoder.sv
// Turns each level change on tog_in into one event, buffered in a saturating pending counter.
// Define TOGGLE_SYNC_EN to pass tog_in through a two-flop synchronizer.
module toggle_event_decoder #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TOTAL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               preset,
    input  logic               tog_in,
    input  logic               evt_ready,
    input  logic               clr_ovf,
    output logic               evt_valid,
    output logic [CNT_W-1:0]   pending,
    output logic [TOTAL_W-1:0] total,
    output logic               overflow
);

    typedef enum logic [1:0] {
        EMPTY,
        ACTIVE,
        FULL
    } pstate_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic             tog_s;
    logic             ref_q;
    logic             det;
    logic             acc;
    pstate_t          state_q;
    pstate_t          state_d;
    logic [CNT_W-1:0] pend_d;
    logic             ovf_d;

`ifdef TOGGLE_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= preset;
            sync2_q <= preset;
        end else begin
            sync1_q <= tog_in;
            sync2_q <= sync1_q;
        end
    end

    assign tog_s = sync2_q;
`else
    logic in_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= preset;
        end else begin
            in_q <= tog_in;
        end
    end

    assign tog_s = in_q;
`endif

    assign evt_valid = (pending != '0);

    always_comb begin
        det     = tog_s ^ ref_q;
        acc     = evt_valid && evt_ready;
        pend_d  = pending;
        // clear is applied first so a same-cycle drop overrides it
        ovf_d   = overflow && !clr_ovf;
        state_d = state_q;
        case ({det, acc})
            2'b10: begin
                if (state_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pending + 1'b1;
                end
            end
            2'b01:   pend_d = pending - 1'b1;
            default: pend_d = pending;
        endcase
        if (pend_d == '0) begin
            state_d = EMPTY;
        end else if (pend_d == PEND_MAX) begin
            state_d = FULL;
        end else begin
            state_d = ACTIVE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q    <= preset;
            state_q  <= EMPTY;
            pending  <= '0;
            total    <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            pending  <= pend_d;
            overflow <= ovf_d;
            if (det) begin
                ref_q <= tog_s;
                total <= total + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Self-checking bench for toggle_event_decoder: cycle model feeding a scoreboard queue plus directed checks.
module tb_toggle_event_decoder;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TOTAL_W = 16;
`ifdef TOGGLE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic               clk;
    logic               rst = 1'b1;
    logic               preset = 1'b1;
    logic               tog_in = 1'b1;
    logic               evt_ready = 1'b0;
    logic               clr_ovf = 1'b0;
    logic               evt_valid;
    logic [CNT_W-1:0]   pending;
    logic [TOTAL_W-1:0] total;
    logic               overflow;

    toggle_event_decoder #(
        .CNT_W  (CNT_W),
        .TOTAL_W(TOTAL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .preset   (preset),
        .tog_in   (tog_in),
        .evt_ready(evt_ready),
        .clr_ovf  (clr_ovf),
        .evt_valid(evt_valid),
        .pending  (pending),
        .total    (total),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic               v;
        logic [CNT_W-1:0]   p;
        logic [TOTAL_W-1:0] t;
        logic               o;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_acc  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, evaluated on the same edges as the DUT
    logic               ms1, ms2, mref, ms, mdet, macc, mfull, movf;
    int unsigned        mp;
    logic [TOTAL_W-1:0] mtot;
    exp_t               enew, eold;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ms1  = preset;
            ms2  = preset;
            mref = preset;
            mp   = 0;
            mtot = '0;
            movf = 1'b0;
            sb.delete();
        end else begin
`ifdef TOGGLE_SYNC_EN
            ms = ms2;
`else
            ms = ms1;
`endif
            mdet  = ms ^ mref;
            macc  = (mp != 0) && evt_ready;
            mfull = (mp == 15);
            if (clr_ovf) movf = 1'b0;
            if (mdet && !macc) begin
                if (mfull) movf = 1'b1;
                else mp++;
            end else if (macc && !mdet) begin
                mp--;
            end
            if (mdet) begin
                mref = ms;
                mtot = mtot + 1'b1;
            end
            ms2    = ms1;
            ms1    = tog_in;
            enew.v = (mp != 0);
            enew.p = mp[CNT_W-1:0];
            enew.t = mtot;
            enew.o = movf;
            sb.push_back(enew);
        end
    end

    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            eold = sb.pop_front();
            check("sb_valid", {31'b0, evt_valid}, {31'b0, eold.v});
            check("sb_pending", {28'b0, pending}, {28'b0, eold.p});
            check("sb_total", {16'b0, total}, {16'b0, eold.t});
            check("sb_overflow", {31'b0, overflow}, {31'b0, eold.o});
        end
    end

    always @(posedge clk) begin
        if (!rst && evt_valid && evt_ready) n_acc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic p);
        rst       = 1'b1;
        preset    = p;
        tog_in    = p;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic toggles(input int n, input int gap);
        repeat (n) begin
            tog_in = ~tog_in;
            tick(gap);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int a0;
    int lat;

    initial begin
        // idle line, both preset levels
        do_reset(1'b1);
        check("rst_valid", {31'b0, evt_valid}, 32'd0);
        check("rst_pending", {28'b0, pending}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        tick(10);
        check("idle1_valid", {31'b0, evt_valid}, 32'd0);
        check("idle1_total", {16'b0, total}, 32'd0);
        do_reset(1'b0);
        tick(10);
        check("idle0_valid", {31'b0, evt_valid}, 32'd0);
        check("idle0_total", {16'b0, total}, 32'd0);

        // three spaced changes, latency of first
        tog_in = ~tog_in;
        lat = 0;
        while (lat < 10 && !evt_valid) begin
            tick();
            lat++;
        end
        check("latency", lat, LAT);
        tick(4 - LAT);
        check("step1_pending", {28'b0, pending}, 32'd1);
        toggles(1, 4);
        check("step2_pending", {28'b0, pending}, 32'd2);
        toggles(1, 4);
        check("step3_pending", {28'b0, pending}, 32'd3);
        check("step3_total", {16'b0, total}, 32'd3);

        // saturation, drain, overflow clear
        do_reset(1'b0);
        toggles(17, 2);
        tick(4);
        check("sat_pending", {28'b0, pending}, 32'd15);
        check("sat_overflow", {31'b0, overflow}, 32'd1);
        check("sat_total", {16'b0, total}, 32'd17);
        a0 = n_acc;
        evt_ready = 1'b1;
        tick(20);
        evt_ready = 1'b0;
        check("drain_accepts", n_acc - a0, 32'd15);
        check("drain_pending", {28'b0, pending}, 32'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_overflow", {31'b0, overflow}, 32'd0);

        // FULL with det and accept in the same cycle
        do_reset(1'b0);
        toggles(15, 2);
        tick(4);
        check("full_pending", {28'b0, pending}, 32'd15);
        a0 = n_acc;
        tog_in = ~tog_in;
        tick(LAT - 1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        tick(2);
        check("full_da_pending", {28'b0, pending}, 32'd15);
        check("full_da_overflow", {31'b0, overflow}, 32'd0);
        check("full_da_total", {16'b0, total}, 32'd16);
        check("full_da_accepts", n_acc - a0, 32'd1);

        // set beats clear in the same cycle
        tog_in = ~tog_in;
        tick(LAT - 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("setwins_overflow", {31'b0, overflow}, 32'd1);
        tick(2);
        check("setwins_sticky", {31'b0, overflow}, 32'd1);

        // toggling every cycle with ready high
        do_reset(1'b1);
        a0 = n_acc;
        evt_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tog_in = ~tog_in;
            tick();
            check("thru_pend_le1", {31'b0, (pending <= 1)}, 32'd1);
        end
        tick(5);
        evt_ready = 1'b0;
        check("thru_accepts", n_acc - a0, 32'd20);
        check("thru_pending", {28'b0, pending}, 32'd0);

        // asynchronous reset mid-stream
        do_reset(1'b0);
        toggles(9, 2);
        tick(4);
        evt_ready = 1'b1;
        tick(4);
        evt_ready = 1'b0;
        check("mid_pending", {28'b0, pending}, 32'd5);
        check("mid_total", {16'b0, total}, 32'd9);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, evt_valid}, 32'd0);
        check("arst_pending", {28'b0, pending}, 32'd0);
        check("arst_total", {16'b0, total}, 32'd0);
        check("arst_overflow", {31'b0, overflow}, 32'd0);
        preset = tog_in;
        tick(2);
        rst = 1'b0;
        tick(10);
        check("post_valid", {31'b0, evt_valid}, 32'd0);
        check("post_total", {16'b0, total}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_event_decoder.md
# toggle_event_decoder

Receiving end of the toggle-signalling scheme built on the T flip-flop. The sender toggles a single level line once per event. This block turns each level change back into one event, buffers the events in a saturating pending counter, and presents them to a consumer through a valid/ready handshake. It also keeps a running total of detected events and a sticky overflow flag. The preset input selects the idle line level, which matches the sender flop's preset so that reset produces no spurious event.

## Interface
Parameters:
- CNT_W, default 4: width of the pending-event counter; maximum pending count is 2^CNT_W-1.
- TOTAL_W, default 16: width of the total-event counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- preset  input  1  idle/reference level of tog_in; sampled while rst is high. Must be static during reset.
- tog_in  input  1  toggle line; each level change is one event.
- evt_ready  input  1  consumer accepts one event when evt_valid && evt_ready.
- clr_ovf  input  1  synchronous clear of overflow.
- evt_valid  output  1  at least one event is pending.
- pending  output  CNT_W  number of pending, unaccepted events.
- total  output  TOTAL_W  detected events modulo 2^TOTAL_W, including dropped events.
- overflow  output  1  sticky; an event was dropped because pending was full.

## Operation
- Input stage: tog_in is registered into tog_s, one flop by default, or two with TOGGLE_SYNC_EN.
- All input-stage flops and the reference level ref_q reset to preset, so the idle line produces no event.
- Detect: det = tog_s ^ ref_q. On det, ref_q <= tog_s. Exactly one event is counted per level change.
- Accept: acc = evt_valid && evt_ready.
- Pending state:
  - EMPTY (pending==0)
  - ACTIVE (0<pending<max)
  - FULL (pending==max)
- Pending update, per cycle:
  - det && !acc: +1, unless FULL, in which case the event is dropped.
  - acc && !det: -1.
  - det && acc: unchanged, including in FULL. Nothing is dropped in this case.
- evt_valid = (pending != 0). It is a function of a register only and never depends on evt_ready.
- evt_ready while EMPTY has no effect.
- total increments on every det, dropped events included, and wraps from 2^TOTAL_W-1 to 0.
- Overflow:
  - Set when det && !acc in FULL.
  - Cleared by clr_ovf.
  - If set and clear occur in the same cycle, set wins.
- Reset values: evt_valid=0, pending=0, total=0, overflow=0, ref_q=preset, input flops=preset.
- Reset mid-operation: all pending events and counts are discarded immediately (asynchronous). Level changes on tog_in during reset are not counted.
- The sender must hold each tog_in level for at least 1 clk cycle. Faster toggling merges events and is not supported.

## Timing
- Latency is counted from the first clk edge that samples a new tog_in level.
  - Default: det is asserted in the following cycle, and pending/evt_valid update at the 2nd edge.
  - With TOGGLE_SYNC_EN: the same happens at the 3rd edge.
- Accept takes effect at the edge where evt_valid && evt_ready is high. pending decrements at that edge.
- Back-to-back accepts drain one event per cycle.
- Sustained throughput is one event per cycle when tog_in changes every cycle and evt_ready=1.
- overflow and total update at the same edge as the pending update for the same det.
- clr_ovf takes effect at the next edge.

## Configuration
- TOGGLE_SYNC_EN defined:
  - tog_in passes through a two-flop synchronizer, both flops reset to preset.
  - Use this when tog_in comes from another clock domain.
  - Detection latency: 3 edges.
- TOGGLE_SYNC_EN undefined:
  - Single input register; tog_in must be synchronous to clk.
  - Detection latency: 2 edges.
- Handshake, counter and overflow behaviour are identical in both builds.

## Test plan
- Reset release, preset=1, tog_in held at 1 for 10 cycles -> evt_valid=0, pending=0, total=0 throughout. Repeat with preset=0 and tog_in=0 -> same result.
- Three tog_in changes spaced 4 cycles apart, evt_ready=0 -> pending steps 1,2,3; total=3; evt_valid rises exactly 2 edges after the first change (3 edges with TOGGLE_SYNC_EN).
- CNT_W=4, 17 changes with evt_ready=0 -> pending saturates at 15, overflow=1, total=17. Then evt_ready=1 for 20 cycles -> exactly 15 accepts and pending=0. clr_ovf -> overflow=0.
- pending=15 (FULL), then a det and an accept in the same cycle -> pending stays 15, overflow stays 0, total increments by 1.
- tog_in toggling every cycle with evt_ready=1 -> pending stays at most 1 and one accept occurs per cycle after the pipeline fill. clr_ovf asserted in the same cycle as an overflow set -> overflow=1.
- rst asserted mid-stream with pending=5 and total=9 -> all outputs 0 immediately without waiting for an edge. After release with tog_in equal to preset, no event is reported.
